// File: rtl/spi_frame_buffer.sv
// spi_frame_buffer: double-buffered word <-> byte converter between a
// processor data bus and an SPI byte shifter. Transmit uses a staging and
// shadow register pair. Receive assembles bytes into rx_shift and hands
// completed words to rx_hold. Byte order is selectable, and the underrun
// and overflow flags are sticky.
module spi_frame_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int SPI_DATA_WIDTH = 8,
    parameter int ATTR_WIDTH     = 4,
    parameter int MSB_FIRST      = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr,
    input  logic [DATA_WIDTH-1:0]     data_in,
    input  logic                      oe,
    output logic [DATA_WIDTH-1:0]     data_out,
    output logic [ATTR_WIDTH-1:0]     attr,
    input  logic                      clr_flags,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      byte_done,
    input  logic [SPI_DATA_WIDTH-1:0] data_in_byte,
    output logic [SPI_DATA_WIDTH-1:0] data_out_byte
);

    localparam int BYTES = DATA_WIDTH / SPI_DATA_WIDTH;
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state, state_nxt;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   stage, shadow;
    logic [DATA_WIDTH-1:0]   rx_shift, rx_hold, rx_word, tx_word;
    logic                    tx_pending, rx_valid, underrun, overflow;
    logic                    active, byte_ok, word_end, swap;
    logic                    set_underrun, set_overflow;
    logic [IDX_W-1:0]        lane, tx_lane;

    // Qualify byte strobes and derive the word-boundary swap. A start or a
    // stop in the same cycle as byte_done wins, so that byte is not counted.
    always_comb begin
        active       = (state == ACTIVE);
        byte_ok      = byte_done && active && !start && !stop;
        word_end     = byte_ok && (idx == LAST);
        swap         = start || word_end;
        lane         = (MSB_FIRST != 0) ? (LAST - idx) : idx;
        // The start cycle always presents the first byte of the new word.
        tx_lane      = start ? ((MSB_FIRST != 0) ? LAST : '0) : lane;
        tx_word      = (start && wr) ? data_in : shadow;
        set_underrun = swap && !wr && !tx_pending;
        set_overflow = word_end && rx_valid && !oe;
    end

    // Wire byte: taken straight from data_in when a write coincides with start.
    always_comb begin
        data_out_byte = tx_word[32'(tx_lane)*SPI_DATA_WIDTH +: SPI_DATA_WIDTH];
    end

    // Received word including the byte arriving this cycle.
    always_comb begin
        rx_word = rx_shift;
        if (byte_ok)
            rx_word[32'(lane)*SPI_DATA_WIDTH +: SPI_DATA_WIDTH] = data_in_byte;
    end

    // Next state: start wins over stop, and a start while active restarts.
    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = ACTIVE;
        else if (stop)
            state_nxt = IDLE;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Byte index and receive shifter. A stop abandons any partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            rx_shift <= '0;
        end else if (start) begin
            idx      <= '0;
            rx_shift <= '0;
        end else if (stop) begin
            idx      <= '0;
        end else if (byte_ok) begin
            rx_shift <= rx_word;
            idx      <= (idx == LAST) ? '0 : idx + 1'b1;
        end
    end

    // Transmit staging and shadow. A write during a swap bypasses stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage      <= '0;
            shadow     <= '0;
            tx_pending <= 1'b0;
        end else if (swap) begin
            if (wr)
                shadow <= data_in;
            else if (tx_pending)
                shadow <= stage;
            else
                shadow <= '0;
            tx_pending <= 1'b0;
        end else if (wr) begin
            stage      <= data_in;
            tx_pending <= 1'b1;
        end
    end

    // Receive hold. A completion in the same cycle as a read keeps rx_valid set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_hold  <= '0;
            rx_valid <= 1'b0;
        end else if (word_end) begin
            rx_hold  <= rx_word;
            rx_valid <= 1'b1;
        end else if (oe) begin
            rx_valid <= 1'b0;
        end
    end

    // Registered read port: returns the pre-update rx_hold, and 0 when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_out <= '0;
        else
            data_out <= oe ? rx_hold : '0;
    end

    // Sticky flags. A set in the same cycle as clr_flags wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (set_underrun)
                underrun <= 1'b1;
            else if (clr_flags)
                underrun <= 1'b0;
            if (set_overflow)
                overflow <= 1'b1;
            else if (clr_flags)
                overflow <= 1'b0;
        end
    end

    // Attribute bus: the low four bits carry status, and the upper bits are zero.
    always_comb begin
        attr    = '0;
        attr[0] = rx_valid;
        attr[1] = tx_pending;
        attr[2] = underrun;
        attr[3] = overflow;
    end

endmodule

// File: doc/spi_frame_buffer.md
Name: spi_frame_buffer

Overview:
- Double-buffered, full-duplex word/byte converter between a processor-unit data bus and an SPI byte shifter.
- Splits DATA_WIDTH-bit words into SPI_DATA_WIDTH-bit bytes for transmit, and assembles received bytes back into words.
- Adds over the single-bank design: a staging/shadow transmit pair, a receive path with hold register, a selectable byte order, and sticky underrun/overflow attributes.

Parameters:
DATA_WIDTH, 32, processor word width; must be a multiple of SPI_DATA_WIDTH.
SPI_DATA_WIDTH, 8, SPI byte width.
ATTR_WIDTH, 4, attribute bus width; must be at least 4.
MSB_FIRST, 1, 1 = most significant byte first on the wire; 0 = least significant byte first.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
wr  in  1  write data_in into the transmit staging register
data_in  in  DATA_WIDTH  transmit word
oe  in  1  read the receive hold register
data_out  out  DATA_WIDTH  registered read data; 0 when not reading
attr  out  ATTR_WIDTH  [0] rx_valid, [1] tx_pending, [2] underrun, [3] overflow; upper bits 0
clr_flags  in  1  clears attr[2] and attr[3]
start  in  1  one-cycle pulse: SPI transaction begins
stop  in  1  one-cycle pulse: SPI transaction ends
byte_done  in  1  one-cycle pulse: one byte exchanged on the wire
data_in_byte  in  SPI_DATA_WIDTH  byte received from the shifter, valid with byte_done
data_out_byte  out  SPI_DATA_WIDTH  byte to transmit; combinational from the shadow register and idx

Behaviour:
- BYTES = DATA_WIDTH/SPI_DATA_WIDTH. idx counts bytes within a word, 0..BYTES-1, and wraps to 0 after the last byte.
- Reset (asynchronous): all registers, data_out and attr go to 0; idx = 0; active = 0. Reset during a transaction aborts it with no flags set.
- Transmit registers:
  - stage: holds the word written by the processor.
  - shadow: holds the word currently on the wire.
  - tx_pending: set when stage holds an unsent word.
  - wr loads stage and sets tx_pending.
- Transmit swap: occurs on start, and on byte_done when idx = BYTES-1 while active.
  - If tx_pending: shadow <= stage and tx_pending clears.
  - Otherwise: shadow <= 0 and underrun is set.
- wr in the same cycle as a swap: data_in goes directly to shadow, tx_pending stays 0, and no underrun is flagged.
- data_out_byte selects byte (BYTES-1-idx) of shadow if MSB_FIRST, otherwise byte idx.
  - On the start cycle with wr high, data_out_byte is taken from data_in, so the first byte sees the new word with zero latency.
- Receive path:
  - On each byte_done while active, data_in_byte is stored into the matching byte lane of rx_shift, using the same ordering as transmit, and idx advances.
  - On the last byte, the completed word (including this byte) goes to rx_hold and rx_valid is set.
  - If rx_valid was already set, overflow is also set and rx_hold is overwritten.
- Read:
  - oe registers data_out <= rx_hold and clears rx_valid; latency is 1 cycle.
  - When oe is low, data_out <= 0.
  - oe in the same cycle as a word completion: data_out gets the old rx_hold, rx_hold gets the new word, rx_valid stays 1, and overflow is not set.
- State machine:
  - IDLE --start--> ACTIVE: idx = 0, rx_shift cleared, swap performed.
  - ACTIVE --stop--> IDLE: idx = 0. A partial received word is discarded (no rx_valid); the partial transmit word is dropped.
  - start while ACTIVE restarts the transaction: same as a stop followed by start in one cycle.
  - byte_done in IDLE is ignored.
  - start and stop in the same cycle: start wins.
- Sticky flags:
  - underrun and overflow stay set until clr_flags or rst.
  - If a flag is set and cleared in the same cycle, set wins.
- Widths: idx is $clog2(BYTES) bits, minimum 1. There is no arithmetic beyond the idx increment and wrap.

Test Plan:
- Basic transmit, defaults: wr data_in=32'hA1B2C3D4, then start, then 4 byte_done pulses -> data_out_byte = A1, B2, C3, D4; attr[1] 1 -> 0 at start.
- Receive: start, then byte_done with data_in_byte 11, 22, 33, 44 -> attr[0]=1 after the 4th pulse; oe -> data_out=32'h11223344 on the next cycle, attr[0]=0, then data_out=0 once oe drops.
- Bypass and underrun: wr 32'hDEADBEEF in the same cycle as start -> first byte DE, no underrun. Let 4 more bytes pass with no wr -> bytes are 00 and attr[2]=1 until clr_flags.
- Overflow and simultaneous read: receive two words without oe -> attr[3]=1 and rx_hold holds the second word. Clear flags, then complete a word while oe is high -> data_out is the old word, attr[0] stays 1, attr[3] stays 0.
- MSB_FIRST=0, DATA_WIDTH=16: wr 16'h1234, start, 2 byte_done -> bytes 34, 12. Received bytes AA, BB -> data_out=16'hBBAA.
- Abort: stop after 2 of 4 bytes -> no rx_valid, idx = 0. Asserting rst mid-transaction sends attr, data_out and data_out_byte to 0 immediately, without waiting for a clock edge.
